mem_req_ctrl: RTL and testbench

Request front-end that sits directly upstream of mem_top and drives its cen/rd/wr/add/din pins. It accepts read/write requests from the system side over a valid/ready handshake and buffers them in a small command FIFO. It sequences each request onto the memory pins as a one-cycle strobe, captures dout after a fixed read latency, and returns read data over a valid/ready response channel. It also owns chip-disable (cen) sequencing, so a disable request never cuts an access in progress.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_req_fifo.sv | 48 ++++
 rtl/mem_req_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_req_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, op codes and FSM states for the
// memory request front-end (optional stats: MEM_REQ_CTRL_STATS_EN).
package mem_ctrl_pkg;

  localparam int DEF_AW = 12;
  localparam int DEF_DW = 8;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    RESP,
    WR
  } state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: command FIFO with wrap-bit pointers.
// Push is refused when full; push and pop may share a cycle.
module mem_req_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AB = $clog2(DEPTH);

  logic [AB:0]  wp;
  logic [AB:0]  rp;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wp == rp);
  assign full  = (wp[AB] != rp[AB]) &&
                 (wp[AB-1:0] == rp[AB-1:0]);
  assign dout  = mem[rp[AB-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + (AB+1)'(1);
      if (pop && !empty)
        rp <= rp + (AB+1)'(1);
    end
  end

  // Storage needs no reset: empty pointers hide stale entries.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AB-1:0]] <= din;
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: queues requests and strobes them onto mem_top pins.
// Define MEM_REQ_CTRL_STATS_EN to add wr_cnt/rd_cnt outputs.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  input  logic          mem_dis,
  output logic          busy,
  output logic          mem_cen,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
`ifdef MEM_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt
`endif
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam int FW = AW + DW + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          h_op;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;

  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == IDLE) && !empty && !mem_cen;
  assign busy      = !empty || (state != IDLE);

  assign {h_op, h_addr, h_wdata} = head;

  mem_req_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({req_op, req_addr, req_wdata}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_cen   <= 1'b1;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_add   <= '0;
      mem_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // cen only moves between accesses
          mem_cen <= mem_dis;
          if (pop) begin
            mem_add <= h_addr;
            if (h_op == OP_WR) begin
              mem_din <= h_wdata;
              mem_wr  <= 1'b1;
              state   <= WR;
            end else begin
              mem_din <= '0;
              mem_rd  <= 1'b1;
              state   <= RD;
            end
          end
        end
        WR: begin
          mem_wr <= 1'b0;
          state  <= IDLE;
        end
        RD: begin
          mem_rd <= 1'b0;
          cnt    <= CW'(RD_LAT - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= mem_dout;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_REQ_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (state == WR)
        wr_cnt <= wr_cnt + 16'd1;
      if (state == RD)
        rd_cnt <= rd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_mem_req_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW     = 12;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 2;
  localparam int MSZ    = 1 << AW;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          mem_dis;
  logic          busy;
  logic          mem_cen;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
`ifdef MEM_REQ_CTRL_STATS_EN
  logic [15:0]   wr_cnt;
  logic [15:0]   rd_cnt;
`endif

  mem_req_ctrl #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_dis   (mem_dis),
    .busy      (busy),
    .mem_cen   (mem_cen),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_add   (mem_add),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
`ifdef MEM_REQ_CTRL_STATS_EN
    ,
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          op;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } acc_t;

  typedef struct {
    logic          op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] exp_add;
    logic [DW-1:0] exp_din;
    logic [DW-1:0] exp_rsp;
  } vec_t;

  int nvec;
  int nerr;

  acc_t          exp_acc [$];
  logic [DW-1:0] exp_rsp [$];
  logic [DW-1:0] tbmem  [MSZ];
  logic [DW-1:0] refmem [MSZ];
  int            pending;
  int            cyc;
  int            rd_due;
  int            rd_issue_cyc;
  int            rd_pulses;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;
  logic          prev_wr;
  logic          prev_rd;
  logic          prev_rspv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Memory stand-in plus scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    acc_t a;
    if (!rst) begin
      exp_acc.delete();
      exp_rsp.delete();
      pending   = 0;
      rd_pend   = 1'b0;
      prev_wr   = 1'b0;
      prev_rd   = 1'b0;
      prev_rspv = 1'b0;
      mem_dout  = '0;
      for (int i = 0; i < MSZ; i++)
        refmem[i] = tbmem[i];
    end else begin
      if (rd_pend && cyc == rd_due) begin
        mem_dout = tbmem[rd_addr];
        rd_pend  = 1'b0;
      end else if (rd_pend) begin
        mem_dout = ~tbmem[rd_addr];
      end else begin
        mem_dout = DW'($urandom);
      end
      chk("busy", busy, pending != 0);
      if (mem_wr || mem_rd) begin
        chk("rd_wr_excl", mem_rd & mem_wr, 0);
        if (exp_acc.size() == 0) begin
          chk("strobe_expected", 0, 1);
        end else begin
          a = exp_acc.pop_front();
          chk("strobe_op", mem_wr, a.op);
          chk("strobe_addr", mem_add, a.addr);
          chk("strobe_din", mem_din, a.op ? a.din : '0);
        end
      end
      if (mem_wr) begin
        chk("wr_width", prev_wr, 0);
        tbmem[mem_add] = mem_din;
        pending--;
      end
      if (mem_rd) begin
        chk("rd_width", prev_rd, 0);
        rd_pend      = 1'b1;
        rd_due       = cyc + RD_LAT;
        rd_addr      = mem_add;
        rd_issue_cyc = cyc;
        rd_pulses++;
      end
      if (rsp_valid && !prev_rspv) begin
        chk("rsp_latency", cyc - rd_issue_cyc, RD_LAT + 1);
        chk("rsp_expected", exp_rsp.size() != 0, 1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0)
          chk("rsp_pop", 0, 1);
        else
          chk("rsp_data", rsp_data, exp_rsp.pop_front());
        pending--;
      end
      if (req_valid && req_ready) begin
        a.op   = req_op;
        a.addr = req_addr;
        a.din  = req_wdata;
        exp_acc.push_back(a);
        if (req_op == OP_WR)
          refmem[req_addr] = req_wdata;
        else
          exp_rsp.push_back(refmem[req_addr]);
        pending++;
      end
      prev_wr   = mem_wr;
      prev_rd   = mem_rd;
      prev_rspv = rsp_valid;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    logic rdy;
    int   n;
    n         = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    do begin
      rdy = req_ready;
      tick();
      n++;
    end while (!rdy && n < 100);
    chk("push_accept", rdy, 1);
    req_valid = 1'b0;
  endtask

  // which: 0 strobe, 1 rsp_valid, 2 idle
  task automatic wait_for(input int which, input string nm,
                          output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      tick();
      n++;
      case (which)
        0:       hit = mem_rd | mem_wr;
        1:       hit = rsp_valid;
        default: hit = !busy;
      endcase
    end
    chk(nm, hit, 1);
  endtask

  vec_t tbl [8];

  initial begin
    int n;
    int r0;
    int dis_cnt;

    tbl[0] = '{OP_WR, 12'h2AA, 8'hAA, 12'h2AA, 8'hAA, 8'h00};
    tbl[1] = '{OP_RD, 12'h2AA, 8'h55, 12'h2AA, 8'h00, 8'hAA};
    tbl[2] = '{OP_WR, 12'h005, 8'h3C, 12'h005, 8'h3C, 8'h00};
    tbl[3] = '{OP_RD, 12'h123, 8'hFF, 12'h123, 8'h00, 8'h79};
    tbl[4] = '{OP_RD, 12'h005, 8'h00, 12'h005, 8'h00, 8'h3C};
    tbl[5] = '{OP_WR, 12'hFFF, 8'hFF, 12'hFFF, 8'hFF, 8'h00};
    tbl[6] = '{OP_RD, 12'hFFF, 8'h00, 12'hFFF, 8'h00, 8'hFF};
    tbl[7] = '{OP_RD, 12'h000, 8'h00, 12'h000, 8'h00, 8'h5A};

    nvec      = 0;
    nerr      = 0;
    cyc       = 0;
    pending   = 0;
    rd_pulses = 0;
    rd_pend   = 1'b0;
    dis_cnt   = 0;
    for (int i = 0; i < MSZ; i++) begin
      tbmem[i]  = DW'(i) ^ 8'h5A;
      refmem[i] = DW'(i) ^ 8'h5A;
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    mem_dis   = 1'b0;

    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cen", mem_cen, 1);
    chk("rst_rd", mem_rd, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_add", mem_add, 0);
    chk("rst_din", mem_din, 0);

    rst       = 1'b1;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("cen_enabled", mem_cen, 0);

    foreach (tbl[i]) begin
      push(tbl[i].op, tbl[i].addr, tbl[i].wdata);
      wait_for(0, "tbl_strobe", n);
      chk("tbl_wr", mem_wr, tbl[i].op);
      chk("tbl_add", mem_add, tbl[i].exp_add);
      chk("tbl_din", mem_din, tbl[i].exp_din);
      if (tbl[i].op == OP_RD) begin
        wait_for(1, "tbl_rsp", n);
        chk("tbl_rsp_data", rsp_data, tbl[i].exp_rsp);
        chk("tbl_rd_lat", n, RD_LAT + 1);
        tick();
      end
    end

    // FIFO full while disabled, then drain in push order
    mem_dis = 1'b1;
    tick();
    tick();
    chk("full_cen", mem_cen, 1);
    for (int k = 0; k < 4; k++)
      push(OP_WR, AW'(12'h101 + k), DW'(8'h11 + k));
    chk("full_ready", req_ready, 0);
    req_valid = 1'b1;
    req_op    = OP_WR;
    req_addr  = 12'h105;
    req_wdata = 8'h15;
    repeat (3) begin
      tick();
      chk("full_hold", req_ready, 0);
    end
    mem_dis = 1'b0;
    wait_for(0, "full_first_wr", n);
    chk("ready_after_pop", req_ready, 1);
    chk("full_order", mem_add, 12'h101);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      wait_for(0, "full_wr", n);
      chk("full_order", mem_add, AW'(12'h101 + k));
    end

    // response backpressure
    rsp_ready = 1'b0;
    push(OP_RD, 12'h102, 8'h00);
    push(OP_RD, 12'h105, 8'h00);
    wait_for(1, "bp_rsp1", n);
    r0 = rd_pulses;
    chk("bp_data1", rsp_data, 8'h12);
    repeat (10) begin
      tick();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 8'h12);
      chk("bp_no_issue", rd_pulses, r0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_released", rsp_valid, 0);
    wait_for(1, "bp_rsp2", n);
    chk("bp_data2", rsp_data, 8'h15);
    tick();

    // disable raised during the read wait
    push(OP_RD, 12'h2AA, 8'h00);
    wait_for(0, "dis_rd", n);
    tick();
    mem_dis = 1'b1;
    chk("dis_cen_wait", mem_cen, 0);
    wait_for(1, "dis_rsp", n);
    chk("dis_data", rsp_data, 8'hAA);
    chk("dis_cen_resp", mem_cen, 0);
    tick();
    chk("dis_cen_idle", mem_cen, 0);
    tick();
    chk("dis_cen_off", mem_cen, 1);
    push(OP_WR, 12'h333, 8'h77);
    repeat (8) begin
      tick();
      chk("dis_no_issue", mem_wr, 0);
      chk("dis_busy", busy, 1);
    end
    mem_dis = 1'b0;
    wait_for(0, "dis_resume", n);
    chk("dis_resume_wr", mem_wr, 1);
    chk("dis_resume_add", mem_add, 12'h333);
    tick();

    // async reset during WAIT with two reads queued
    push(OP_RD, 12'h333, 8'h00);
    push(OP_RD, 12'h101, 8'h00);
    push(OP_RD, 12'h102, 8'h00);
    chk("arst_pre_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cen", mem_cen, 1);
    chk("arst_rd", mem_rd, 0);
    chk("arst_wr", mem_wr, 0);
    chk("arst_add", mem_add, 0);
    chk("arst_din", mem_din, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 1);
    tick();
    tick();
    rst = 1'b1;
    repeat (20) begin
      tick();
      chk("arst_no_rsp", rsp_valid, 0);
      chk("arst_no_strobe", mem_rd | mem_wr, 0);
    end

    // 3 writes, 2 reads from a clean reset
    push(OP_WR, 12'h010, 8'h01);
    push(OP_WR, 12'h011, 8'h02);
    push(OP_WR, 12'h012, 8'h03);
    push(OP_RD, 12'h010, 8'h00);
    push(OP_RD, 12'h012, 8'h00);
    wait_for(2, "stats_drain", n);
`ifdef MEM_REQ_CTRL_STATS_EN
    chk("wr_cnt", wr_cnt, 3);
    chk("rd_cnt", rd_cnt, 2);
`endif

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_op    = 1'($urandom_range(0, 1));
      req_addr  = 12'h400 | AW'($urandom_range(0, 7));
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (dis_cnt > 0)
        dis_cnt--;
      else if ($urandom_range(0, 39) == 0)
        dis_cnt = 6;
      mem_dis = (dis_cnt != 0);
      tick();
    end
    req_valid = 1'b0;
    mem_dis   = 1'b0;
    rsp_ready = 1'b1;
    wait_for(2, "rand_drain", n);
    chk("rand_acc_left", exp_acc.size(), 0);
    chk("rand_rsp_left", exp_rsp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
